// File: rtl/hyperbus_trans_arb.sv
// Round-robin arbiter that hands the single HyperBus transaction channel to one requester per transfer.
// Optional watchdog in WAIT_DONE is enabled with `define HYPERBUS_TRANS_ARB_TIMEOUT_EN.
module hyperbus_trans_arb #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned NumChips      = 2,
  parameter type         trans_t       = logic [31:0],
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  trans_t [NumReq-1:0]                req_trans_i,
  input  logic   [NumReq-1:0][NumChips-1:0]  req_cs_i,
  input  logic   [NumReq-1:0]                req_write_i,
  input  logic   [NumReq-1:0]                req_valid_i,
  output logic   [NumReq-1:0]                req_ready_o,
  output trans_t                             trans_o,
  output logic   [NumChips-1:0]              trans_cs_o,
  output logic                               trans_valid_o,
  input  logic                               trans_ready_i,
  input  logic                               b_valid_i,
  input  logic                               b_ready_i,
  input  logic                               rx_valid_i,
  input  logic                               rx_ready_i,
  input  logic                               rx_last_i,
  output logic   [$clog2(NumReq)-1:0]        gnt_idx_o,
  output logic                               busy_o,
  output logic                               timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

  state_e          state_reg, state_next;
  logic [IdxW-1:0] gnt_reg, gnt_next;
  logic [IdxW-1:0] rr_reg, rr_next;
  logic            write_reg, write_next;
  logic [IdxW-1:0] sel_idx, gnt_inc;
  logic            sel_found;
  logic            done;
  logic            expire;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      rr_reg    <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      rr_reg    <= rr_next;
      write_reg <= write_next;
    end
  end

  // First valid requester at or after the pointer, wrapping past NumReq-1.
  always_comb begin
    int unsigned     cand_wide;
    logic [IdxW-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_wide = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand_wide = 32'(rr_reg) + i;
      if (cand_wide >= NumReq) cand_wide = cand_wide - NumReq;
      cand = IdxW'(cand_wide);
      if (!sel_found && req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign gnt_inc = (gnt_reg == IdxW'(NumReq - 1)) ? '0 : gnt_reg + 1'b1;
  assign done    = write_reg ? (b_valid_i & b_ready_i)
                             : (rx_valid_i & rx_ready_i & rx_last_i);

`ifdef HYPERBUS_TRANS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_reg <= '0;
    else         cnt_reg <= cnt_next;
  end

  // Held at zero outside WAIT_DONE so every transfer starts its wait from zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg != WAIT_DONE) cnt_next = '0;
    else if (!expire)           cnt_next = cnt_reg + 1'b1;
  end

  assign expire = (state_reg == WAIT_DONE) && (cnt_reg == CntW'(TimeoutCycles));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    rr_next    = rr_reg;
    write_next = write_reg;
    unique case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next = ISSUE;
          gnt_next   = sel_idx;
          write_next = req_write_i[sel_idx];
        end
      end
      ISSUE: begin
        // A requester withdrawing its valid loses the slot without moving the pointer.
        if (!req_valid_i[gnt_reg])  state_next = IDLE;
        else if (trans_ready_i)     state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done || expire) begin
          state_next = IDLE;
          rr_next    = gnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_reg != IDLE);
    trans_valid_o = (state_reg == ISSUE) && req_valid_i[gnt_reg];
    trans_o       = req_trans_i[gnt_reg];
    trans_cs_o    = req_cs_i[gnt_reg];
    timeout_o     = expire && !done;
  end

  assign gnt_idx_o = gnt_reg;

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
      assign req_ready_o[gi] = (state_reg == ISSUE) && (gnt_reg == IdxW'(gi)) && trans_ready_i;
    end
  endgenerate

endmodule

// File: tb/tb_hyperbus_trans_arb.sv
// Bench for hyperbus_trans_arb: transfer-level reference model checked every cycle, plus directed scenarios.
// Timeout expectations follow `define HYPERBUS_TRANS_ARB_TIMEOUT_EN.
module tb_hyperbus_trans_arb;
  localparam int N  = 4;
  localparam int C  = 2;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N-1:0][31:0]   req_trans;
  logic [N-1:0][C-1:0]  req_cs;
  logic [N-1:0]         req_write = '0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [31:0]          trans;
  logic [C-1:0]         trans_cs;
  logic                 trans_valid;
  logic                 trans_ready = 1'b0;
  logic                 b_valid = 1'b0, b_ready = 1'b0;
  logic                 rx_valid = 1'b0, rx_ready = 1'b0, rx_last = 1'b0;
  logic [1:0]           gnt_idx;
  logic                 busy;
  logic                 timeout;

  int checks = 0;
  int errors = 0;
  int hs_q[$];

  // Transfer-level model: who owns the channel, whether its request was taken, how long it waited.
  bit m_busy = 0, m_issued = 0, m_write = 0;
  int m_owner = 0, m_rr = 0, m_wait = 0;

  always #5 clk = ~clk;

  hyperbus_trans_arb #(
    .NumReq(N), .NumChips(C), .trans_t(logic [31:0]), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_trans_i(req_trans), .req_cs_i(req_cs), .req_write_i(req_write),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .trans_o(trans), .trans_cs_o(trans_cs), .trans_valid_o(trans_valid),
    .trans_ready_i(trans_ready),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .rx_valid_i(rx_valid), .rx_ready_i(rx_ready), .rx_last_i(rx_last),
    .gnt_idx_o(gnt_idx), .busy_o(busy), .timeout_o(timeout)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_seq(string name, int n, int e0, int e1, int e2, int e3, int e4);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    chk({name, "_len"}, hs_q.size(), n);
    for (int i = 0; i < n && i < hs_q.size(); i++) chk({name, "_grant"}, hs_q[i], e[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_comp(bit v);
    b_valid = v; b_ready = v; rx_valid = v; rx_ready = v; rx_last = v;
  endtask

  // Compare against the model on the falling edge, then advance the model with the inputs the DUT will sample.
  initial begin
    forever begin
      bit             exp_tv, cdone, exp_to;
      logic [N-1:0]   exp_rdy;
      @(negedge clk);
      exp_tv  = m_busy && !m_issued && req_valid[m_owner];
      exp_rdy = '0;
      if (m_busy && !m_issued) exp_rdy[m_owner] = trans_ready;
      cdone = m_write ? (b_valid && b_ready) : (rx_valid && rx_ready && rx_last);
`ifdef HYPERBUS_TRANS_ARB_TIMEOUT_EN
      exp_to = m_busy && m_issued && (m_wait == TO) && !cdone;
`else
      exp_to = 1'b0;
`endif
      chk("busy", busy, m_busy);
      chk("gnt_idx", gnt_idx, m_owner);
      chk("trans_valid", trans_valid, exp_tv);
      chk("req_ready", req_ready, exp_rdy);
      chk("timeout", timeout, exp_to);
      if (exp_tv) begin
        chk("trans", trans, req_trans[m_owner]);
        chk("trans_cs", trans_cs, req_cs[m_owner]);
      end
      if (trans_valid && trans_ready) begin
        hs_q.push_back(int'(gnt_idx));
        $display("%0t transfer: owner=%0d write=%0b trans=%h cs=%b", $time, gnt_idx,
                 req_write[gnt_idx], trans, trans_cs);
      end

      if (!rst_ni) begin
        m_busy = 0; m_issued = 0; m_write = 0; m_owner = 0; m_rr = 0; m_wait = 0;
      end else if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (req_valid[c]) begin
            m_busy = 1; m_issued = 0; m_owner = c; m_write = req_write[c];
            break;
          end
        end
      end else if (!m_issued) begin
        if (!req_valid[m_owner]) m_busy = 0;
        else if (trans_ready) begin m_issued = 1; m_wait = 0; end
      end else if (cdone || exp_to) begin
        m_busy = 0; m_issued = 0; m_rr = (m_owner + 1) % N;
      end else begin
        m_wait++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, errors so far %0d", errors);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int pulses, pulse_at;
    for (int i = 0; i < N; i++) begin
      req_trans[i] = 32'hC0DE_0000 + 32'(i);
    end
    req_cs[0] = 2'b01; req_cs[1] = 2'b10; req_cs[2] = 2'b11; req_cs[3] = 2'b01;

    // Reset with every requester asking.
    req_valid = 4'hF;
    rst_ni    = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", trans_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gnt", gnt_idx, 0);
    chk("rst_timeout", timeout, 0);
    rst_ni = 1'b1;
    chk("rel_tvalid_sel", trans_valid, 0);
    tick();
    chk("rel_tvalid", trans_valid, 1);
    chk("rel_gnt", gnt_idx, 0);

    // Back-pressure from the CDC for 10 cycles.
    repeat (10) tick();
    chk("hold_tvalid", trans_valid, 1);
    chk("hold_gnt", gnt_idx, 0);
    chk("hold_ready", req_ready, 0);
    chk("hold_trans", trans, 32'hC0DE_0000);
    chk("hold_cs", trans_cs, 2'b01);
    trans_ready = 1'b1;
    tick();
    trans_ready = 1'b0;
    chk("hs_busy", busy, 1);
    chk("hs_tvalid", trans_valid, 0);
    chk_seq("hs_once", 1, 0, 0, 0, 0, 0);
    // Read transfer: a B handshake must not end it, the last RX beat does.
    b_valid = 1'b1; b_ready = 1'b1;
    tick();
    b_valid = 1'b0; b_ready = 1'b0;
    chk("read_ignores_b", busy, 1);
    rx_valid = 1'b1; rx_ready = 1'b1; rx_last = 1'b1;
    tick();
    rx_valid = 1'b0; rx_ready = 1'b0; rx_last = 1'b0;
    chk("read_done", busy, 0);
    req_valid = '0;
    hs_q.delete();

    // All requesters continuously valid, instant completions; pointer currently at 1.
    req_valid = 4'hF; req_write = 4'b0101; trans_ready = 1'b1; set_comp(1);
    repeat (15) tick();
    req_valid = '0; trans_ready = 1'b0; set_comp(0);
    chk_seq("rr_order", 5, 1, 2, 3, 0, 1);
    hs_q.delete();

    // req1 write: RX last during WAIT_DONE is ignored, B ends it; req2 wins the next round.
    req_write = 4'b0010; req_valid = 4'b0010; trans_ready = 1'b1;
    tick();
    chk("w_gnt", gnt_idx, 1);
    tick();
    trans_ready = 1'b0; req_valid = '0;
    rx_valid = 1'b1; rx_ready = 1'b1; rx_last = 1'b1;
    tick();
    rx_valid = 1'b0; rx_ready = 1'b0; rx_last = 1'b0;
    chk("w_ignores_rx", busy, 1);
    b_valid = 1'b1; b_ready = 1'b1; req_valid = 4'b1110; req_write = 4'b0000;
    tick();
    b_valid = 1'b0; b_ready = 1'b0;
    chk("w_done", busy, 0);
    tick();
    chk("w_next_busy", busy, 1);
    chk("w_next_gnt", gnt_idx, 2);
    trans_ready = 1'b1;
    tick();
    trans_ready = 1'b0; req_valid = '0;
    rx_valid = 1'b1; rx_ready = 1'b1; rx_last = 1'b1;
    tick();
    rx_valid = 1'b0; rx_ready = 1'b0; rx_last = 1'b0;
    chk("w_next_done", busy, 0);
    hs_q.delete();

    // Pointer wrap: only req3, then only req0.
    req_valid = 4'b1000; trans_ready = 1'b1; set_comp(1);
    repeat (3) tick();
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = '0; trans_ready = 1'b0; set_comp(0);
    tick(); tick();
    chk_seq("wrap", 2, 3, 0, 0, 0, 0);
    chk("wrap_idle", busy, 0);

    // Granted valid withdrawn in ISSUE: back to IDLE, pointer unchanged (still 1).
    req_valid = 4'b0010;
    tick();
    chk("drop_gnt", gnt_idx, 1);
    req_valid = '0;
    tick();
    chk("drop_busy", busy, 0);
    chk("drop_gnt_held", gnt_idx, 1);
    req_valid = 4'b0011;
    tick();
    chk("drop_regnt", gnt_idx, 1);
    trans_ready = 1'b1;
    tick();
    trans_ready = 1'b0; req_valid = '0;
    rx_valid = 1'b1; rx_ready = 1'b1; rx_last = 1'b1;
    tick();
    rx_valid = 1'b0; rx_ready = 1'b0; rx_last = 1'b0;
    chk("drop_done", busy, 0);

    // Write with no completion ever arriving.
    req_valid = 4'b0100; req_write = 4'b0100; trans_ready = 1'b1;
    tick(); tick();
    trans_ready = 1'b0; req_valid = '0;
    pulses = 0; pulse_at = -1;
    for (int k = 0; k < 12; k++) begin
      if (timeout) begin pulses++; pulse_at = k; end
      tick();
    end
`ifdef HYPERBUS_TRANS_ARB_TIMEOUT_EN
    chk("to_pulses", pulses, 1);
    chk("to_pulse_at", pulse_at, 8);
    chk("to_busy", busy, 0);
`else
    chk("to_pulses", pulses, 0);
    chk("to_busy", busy, 1);
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_gnt", gnt_idx, 0);
`endif
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
